// File: rtl/rx_rst_seq_if.sv
// ----------------------------------------------------------------------------
// rx_rst_seq_if
//   Bundle between the RX reset sequencer and its environment.
//
//   init_rst_in : power-on reset counter level, 1 = hold the RX chain in reset
//   lock_in     : front-end/ADC lock indication, synchronous to clk
//   stage_rst   : per-stage active-high resets, bit 0 = first RX stage
//   ready       : high while the chain is running
//   start_pulse : one-cycle pulse when the chain starts running
//   err_timeout : sticky flag, lock never qualified
//   state_dbg   : encoded sequencer state (HOLD=0 .. FAULT=4)
//
//   slave  : sequencer side (drives the status/reset outputs)
//   master : environment side (drives init_rst_in and lock_in)
// ----------------------------------------------------------------------------
interface rx_rst_seq_if #(
    parameter int N_STAGES = 4
);
    logic                init_rst_in;
    logic                lock_in;
    logic [N_STAGES-1:0] stage_rst;
    logic                ready;
    logic                start_pulse;
    logic                err_timeout;
    logic [2:0]          state_dbg;

    modport slave (
        input  init_rst_in,
        input  lock_in,
        output stage_rst,
        output ready,
        output start_pulse,
        output err_timeout,
        output state_dbg
    );

    modport master (
        output init_rst_in,
        output lock_in,
        input  stage_rst,
        input  ready,
        input  start_pulse,
        input  err_timeout,
        input  state_dbg
    );
endinterface

// File: rtl/rx_rst_seq.sv
// ----------------------------------------------------------------------------
// rx_rst_seq
//   Releases the per-stage resets of the RX chain one at a time once the
//   front-end lock has been stable for LOCK_FILT cycles, spacing releases by
//   STAGE_GAP cycles, then raises ready and a one-cycle start pulse. A new
//   init reset or a lock loss puts every stage back into reset. If lock never
//   qualifies within TIMEOUT cycles the sequencer parks in FAULT with a sticky
//   err_timeout until the next init reset.
//
//   clk : system clock, everything on posedge
//   rst : asynchronous active-high reset
//   bus : rx_rst_seq_if.slave (init_rst_in, lock_in in; stage_rst, ready,
//         start_pulse, err_timeout, state_dbg out). All outputs registered.
// ----------------------------------------------------------------------------
module rx_rst_seq #(
    parameter int N_STAGES  = 4,
    parameter int STAGE_GAP = 16,
    parameter int LOCK_FILT = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic           clk,
    input  logic           rst,
    rx_rst_seq_if.slave    bus
);

    localparam int LOCK_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int TO_W   = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;
    // k must be able to hold N_STAGES itself (the "all released" value).
    localparam int K_W    = $clog2(N_STAGES + 1);

    localparam logic [LOCK_W-1:0]   LOCK_LAST = LOCK_W'(LOCK_FILT - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [K_W-1:0]      K_ALL     = K_W'(N_STAGES);
    localparam logic [N_STAGES-1:0] ALL_ONES  = {N_STAGES{1'b1}};

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t              state,       state_nxt;
    logic [N_STAGES-1:0] stage_rst,   stage_rst_nxt;
    logic                ready,       ready_nxt;
    logic                start_pulse, start_pulse_nxt;
    logic                err_timeout, err_timeout_nxt;
    logic [LOCK_W-1:0]   lock_cnt,    lock_cnt_nxt;
    logic [GAP_W-1:0]    gap_cnt,     gap_cnt_nxt;
    logic [K_W-1:0]      k,           k_nxt;
    logic [TO_W-1:0]     to_cnt,      to_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HOLD;
            stage_rst   <= ALL_ONES;
            ready       <= 1'b0;
            start_pulse <= 1'b0;
            err_timeout <= 1'b0;
            lock_cnt    <= '0;
            gap_cnt     <= '0;
            k           <= '0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            stage_rst   <= stage_rst_nxt;
            ready       <= ready_nxt;
            start_pulse <= start_pulse_nxt;
            err_timeout <= err_timeout_nxt;
            lock_cnt    <= lock_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            k           <= k_nxt;
            to_cnt      <= to_cnt_nxt;
        end
    end

    // Stages are released strictly in order, so releasing the next stage is
    // a left shift of the reset vector with a zero shifted into bit 0.
    always_comb begin
        state_nxt       = state;
        stage_rst_nxt   = stage_rst;
        ready_nxt       = 1'b0;
        start_pulse_nxt = 1'b0;
        err_timeout_nxt = err_timeout;
        lock_cnt_nxt    = lock_cnt;
        gap_cnt_nxt     = gap_cnt;
        k_nxt           = k;
        to_cnt_nxt      = to_cnt;

        if (bus.init_rst_in) begin
            state_nxt       = HOLD;
            stage_rst_nxt   = ALL_ONES;
            err_timeout_nxt = 1'b0;
            lock_cnt_nxt    = '0;
            gap_cnt_nxt     = '0;
            k_nxt           = '0;
            to_cnt_nxt      = '0;
        end else begin
            unique case (state)
                HOLD: begin
                    stage_rst_nxt = ALL_ONES;
                    state_nxt     = WAIT_LOCK;
                    lock_cnt_nxt  = '0;
                    to_cnt_nxt    = '0;
                end

                WAIT_LOCK: begin
                    stage_rst_nxt = ALL_ONES;
                    if (bus.lock_in && lock_cnt == LOCK_LAST) begin
                        // Qualification wins over a coincident timeout.
                        state_nxt     = RELEASE;
                        stage_rst_nxt = ALL_ONES << 1;
                        k_nxt         = K_W'(1);
                        gap_cnt_nxt   = '0;
                        lock_cnt_nxt  = '0;
                        to_cnt_nxt    = '0;
                    end else if (to_cnt == TO_LAST) begin
                        state_nxt       = FAULT;
                        err_timeout_nxt = 1'b1;
                        lock_cnt_nxt    = '0;
                        to_cnt_nxt      = '0;
                    end else begin
                        to_cnt_nxt   = to_cnt + TO_W'(1);
                        lock_cnt_nxt = bus.lock_in ? lock_cnt + LOCK_W'(1) : '0;
                    end
                end

                RELEASE: begin
                    if (!bus.lock_in) begin
                        state_nxt     = WAIT_LOCK;
                        stage_rst_nxt = ALL_ONES;
                        lock_cnt_nxt  = '0;
                        gap_cnt_nxt   = '0;
                        k_nxt         = '0;
                        to_cnt_nxt    = '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt_nxt = '0;
                        if (k == K_ALL) begin
                            state_nxt       = RUN;
                            ready_nxt       = 1'b1;
                            start_pulse_nxt = 1'b1;
                            k_nxt           = '0;
                        end else begin
                            stage_rst_nxt = stage_rst << 1;
                            k_nxt         = k + K_W'(1);
                        end
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end

                RUN: begin
                    if (!bus.lock_in) begin
                        state_nxt     = WAIT_LOCK;
                        stage_rst_nxt = ALL_ONES;
                        lock_cnt_nxt  = '0;
                        gap_cnt_nxt   = '0;
                        k_nxt         = '0;
                        to_cnt_nxt    = '0;
                    end else begin
                        stage_rst_nxt = '0;
                        ready_nxt     = 1'b1;
                    end
                end

                FAULT: begin
                    // Lock is ignored here; only an init reset or rst leaves.
                    stage_rst_nxt   = ALL_ONES;
                    err_timeout_nxt = 1'b1;
                end

                default: begin
                    state_nxt     = HOLD;
                    stage_rst_nxt = ALL_ONES;
                    lock_cnt_nxt  = '0;
                    gap_cnt_nxt   = '0;
                    k_nxt         = '0;
                    to_cnt_nxt    = '0;
                end
            endcase
        end
    end

    assign bus.stage_rst   = stage_rst;
    assign bus.ready       = ready;
    assign bus.start_pulse = start_pulse;
    assign bus.err_timeout = err_timeout;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_rx_rst_seq.sv
// ----------------------------------------------------------------------------
// tb_rx_rst_seq
//   Directed bench for rx_rst_seq (N_STAGES=4, STAGE_GAP=16, LOCK_FILT=8,
//   TIMEOUT=64). A table of {inputs, cycles to run, expected outputs} rows
//   walks the sequencer through release, lock loss, filter restart, mid-
//   release init reset and lock timeout; hand-written code covers the
//   asynchronous rst case.
// ----------------------------------------------------------------------------
module tb_rx_rst_seq;

    localparam int N  = 4;
    localparam int G  = 16;
    localparam int LF = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_rst_seq_if #(.N_STAGES(N)) bus ();

    rx_rst_seq #(
        .N_STAGES (N),
        .STAGE_GAP(G),
        .LOCK_FILT(LF),
        .TIMEOUT  (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        init;
        logic        lock;
        int unsigned n;
        logic [3:0]  stage;
        logic        rdy;
        logic        st;
        logic        err;
        logic [2:0]  state;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [3:0] F = 4'b1111;

    task automatic add(input logic init, input logic lock, input int unsigned n,
                       input logic [3:0] stage, input logic rdy, input logic st,
                       input logic err, input logic [2:0] state);
        vec_t v;
        v.init = init; v.lock = lock; v.n = n; v.stage = stage;
        v.rdy = rdy; v.st = st; v.err = err; v.state = state;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] stage, input logic rdy,
                             input logic st, input logic err, input logic [2:0] state);
        check({tag, ".stage_rst"},   32'(bus.stage_rst),   32'(stage));
        check({tag, ".ready"},       32'(bus.ready),       32'(rdy));
        check({tag, ".start_pulse"}, 32'(bus.start_pulse), 32'(st));
        check({tag, ".err_timeout"}, 32'(bus.err_timeout), 32'(err));
        check({tag, ".state_dbg"},   32'(bus.state_dbg),   32'(state));
    endtask

    initial begin
        // Sequence 1: power-up release with lock high throughout
        add(1, 1, 2,  F,       0, 0, 0, 0);
        add(0, 1, 1,  F,       0, 0, 0, 1);
        add(0, 1, 7,  F,       0, 0, 0, 1);
        add(0, 1, 1,  4'b1110, 0, 0, 0, 2);
        add(0, 1, 15, 4'b1110, 0, 0, 0, 2);
        add(0, 1, 1,  4'b1100, 0, 0, 0, 2);
        add(0, 1, 16, 4'b1000, 0, 0, 0, 2);
        add(0, 1, 16, 4'b0000, 0, 0, 0, 2);
        add(0, 1, 15, 4'b0000, 0, 0, 0, 2);
        add(0, 1, 1,  4'b0000, 1, 1, 0, 3);
        add(0, 1, 1,  4'b0000, 1, 0, 0, 3);
        add(0, 1, 5,  4'b0000, 1, 0, 0, 3);
        // Sequence 3: one-cycle lock loss in RUN, then full re-sequence
        add(0, 0, 1,  F,       0, 0, 0, 1);
        add(0, 1, 7,  F,       0, 0, 0, 1);
        add(0, 1, 1,  4'b1110, 0, 0, 0, 2);
        add(0, 1, 63, 4'b0000, 0, 0, 0, 2);
        add(0, 1, 1,  4'b0000, 1, 1, 0, 3);
        // Sequence 2: lock glitch restarts the filter
        add(1, 1, 1,  F,       0, 0, 0, 0);
        add(0, 1, 1,  F,       0, 0, 0, 1);
        add(0, 1, 7,  F,       0, 0, 0, 1);
        add(0, 0, 1,  F,       0, 0, 0, 1);
        add(0, 1, 7,  F,       0, 0, 0, 1);
        add(0, 1, 1,  4'b1110, 0, 0, 0, 2);
        // Sequence 5: init reset mid-release, no start pulse afterwards
        add(0, 1, 16, 4'b1100, 0, 0, 0, 2);
        add(1, 1, 1,  F,       0, 0, 0, 0);
        add(1, 1, 70, F,       0, 0, 0, 0);
        // Sequence 4: lock timeout into FAULT, lock ignored, init clears it
        add(0, 0, 1,  F,       0, 0, 0, 1);
        add(0, 0, 63, F,       0, 0, 0, 1);
        add(0, 0, 1,  F,       0, 0, 1, 4);
        add(0, 1, 20, F,       0, 0, 1, 4);
        add(1, 1, 1,  F,       0, 0, 0, 0);
        // Bring the chain back to RUN for the async reset case
        add(0, 1, 1,  F,       0, 0, 0, 1);
        add(0, 1, 8,  4'b1110, 0, 0, 0, 2);
        add(0, 1, 64, 4'b0000, 1, 1, 0, 3);
        add(0, 1, 3,  4'b0000, 1, 0, 0, 3);

        rst             = 1'b1;
        bus.init_rst_in = 1'b1;
        bus.lock_in     = 1'b1;
        #12;
        check_all("reset", F, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            bus.init_rst_in = vecs[i].init;
            bus.lock_in     = vecs[i].lock;
            repeat (vecs[i].n) @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].stage, vecs[i].rdy,
                      vecs[i].st, vecs[i].err, vecs[i].state);
        end

        // Sequence 6: asynchronous rst between edges while in RUN
        #3;
        rst = 1'b1;
        #1;
        check_all("async_rst", F, 0, 0, 0, 0);
        // rst high with init low: stays in HOLD
        bus.init_rst_in = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_all("rst_held", F, 0, 0, 0, 0);
        // rst low but init still high: stays in HOLD
        bus.init_rst_in = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_all("init_held", F, 0, 0, 0, 0);
        // both low: sequencing resumes
        bus.init_rst_in = 1'b0;
        @(posedge clk); #1;
        check_all("resume", F, 0, 0, 0, 1);
        repeat (8) @(posedge clk); #1;
        check_all("resume_rel", 4'b1110, 0, 0, 0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_rst_seq.md
Name: rx_rst_seq

Overview:
- Downstream consumer of the RX power-on reset counter output (init_rst_in, active-high, held ~1 k cycles after rst).
- Waits for a qualified front-end lock, then releases the per-stage resets of the RX chain one stage at a time, in order, at fixed spacing.
- Issues a one-cycle start pulse and a ready level once every stage is out of reset.
- Reasserts all stage resets on a new init reset or on lock loss. Flags a sticky fault if lock never qualifies.

Parameters:
N_STAGES, 4, number of stage_rst outputs, released in order from bit 0 to bit N_STAGES-1; minimum 1.
STAGE_GAP, 16, cycles between successive stage releases, and from the last release to RUN; minimum 1.
LOCK_FILT, 8, consecutive cycles lock_in must be sampled high in WAIT_LOCK to qualify; minimum 1.
TIMEOUT, 4096, maximum cycles spent in WAIT_LOCK before FAULT.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
init_rst_in  in  1  level from the power-on reset counter; 1 = hold RX in reset.
lock_in  in  1  front-end/ADC lock indication, synchronous to clk.
stage_rst  out  N_STAGES  per-stage active-high resets; bit 0 = first stage in the RX chain.
ready  out  1  high while in RUN.
start_pulse  out  1  one-cycle pulse on entry to RUN.
err_timeout  out  1  sticky lock-timeout flag.
state_dbg  out  3  encoded FSM state: HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4.

Behaviour:
- Outputs and timing
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Async rst values
  - state=HOLD, stage_rst=all 1s, ready=0, start_pulse=0, err_timeout=0.
  - lock_cnt, gap_cnt, stage index k and timeout counter all cleared.
- Counter widths
  - Each counter is $clog2 of its limit, with a minimum width of 1.
  - Counters never wrap: they either saturate or are cleared on state exit.
- Priority each edge
  - init_rst_in=1 is highest priority.
  - Lock loss (lock_in=0 in RELEASE or RUN) is next.
  - Lock qualification beats timeout.
- init_rst_in=1 in any state
  - Next state is HOLD.
  - stage_rst=all 1s, ready=0, err_timeout cleared, all counters cleared.
- HOLD
  - stage_rst=all 1s.
  - Stays while init_rst_in=1; init_rst_in=0 -> WAIT_LOCK.
  - lock_cnt and the timeout counter are cleared on entry to WAIT_LOCK.
- WAIT_LOCK
  - lock_in=1: lock_cnt++.
  - lock_in=0: lock_cnt<=0.
  - Qualification: lock_in=1 with lock_cnt==LOCK_FILT-1 -> RELEASE. Lock therefore qualifies on the LOCK_FILT-th edge after entry, if it is high throughout.
  - Timeout: the timeout counter increments every cycle. Reaching TIMEOUT-1 without qualifying -> FAULT.
- Entry to RELEASE (same edge)
  - stage_rst[0]<=0, k<=1, gap_cnt<=0.
- RELEASE
  - gap_cnt++ each cycle.
  - At gap_cnt==STAGE_GAP-1 with k<N_STAGES: stage_rst[k]<=0, k++, gap_cnt<=0.
  - At gap_cnt==STAGE_GAP-1 with k==N_STAGES: -> RUN, with ready<=1 and start_pulse<=1 on that edge.
  - Resulting timing: stage i is released STAGE_GAP*i cycles after stage 0, and RUN is entered STAGE_GAP*N_STAGES cycles after stage 0.
  - Released bits stay 0 until a reassertion event.
- RUN
  - ready=1, stage_rst=all 0s.
  - start_pulse is high exactly one cycle.
- Lock loss in RELEASE or RUN
  - Next edge: stage_rst=all 1s, ready=0, start_pulse=0, -> WAIT_LOCK with counters cleared.
  - err_timeout is unchanged.
- FAULT
  - stage_rst=all 1s, err_timeout=1.
  - lock_in is ignored.
  - Exits only via init_rst_in=1 (-> HOLD) or rst.
- N_STAGES=1
  - RUN is entered STAGE_GAP cycles after stage 0 is released.

Test Plan:
1. Defaults, rst then init_rst_in falling, lock_in=1 throughout -> WAIT_LOCK 1 cycle later. Then:
   - stage_rst[0]=0 eight cycles after WAIT_LOCK entry.
   - Bits 1, 2, 3 clear at +16, +32 and +48 cycles after stage 0.
   - ready=1 and a single-cycle start_pulse at +64.
2. In WAIT_LOCK, lock_in high 7 cycles, low 1, then high -> no release until 8 further consecutive high cycles; lock_cnt restarts from 0.
3. In RUN, lock_in low one cycle -> next edge stage_rst=4'b1111, ready=0, state_dbg=1. Restoring lock repeats the full 8 + 64 cycle sequence.
4. TIMEOUT=64, lock_in=0 -> FAULT at cycle 63 of WAIT_LOCK with err_timeout=1. Asserting lock_in causes no change. A pulse on init_rst_in -> HOLD with err_timeout=0.
5. init_rst_in=1 mid-RELEASE, after stage_rst=4'b1100 -> next edge stage_rst=4'b1111, state_dbg=0. No start_pulse.
6. rst asserted asynchronously between clock edges while in RUN -> outputs reach their reset values immediately, without waiting for a clock edge. Sequencing resumes only after rst and init_rst_in are both low.
